// File: rtl/crypt_pkg.sv
// Shared types and constants for the block-cipher job controller.
package crypt_pkg;

    localparam int unsigned NBYTES  = 16;
    localparam int unsigned KEY_W   = 10;
    localparam int unsigned BLOCK_W = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_UNLOAD
    } state_t;

    function automatic int unsigned byte_lane(input int unsigned i);
        return 8 * i;
    endfunction

endpackage

// File: rtl/crypt_byte_serdes.sv
// Byte-serial load register file feeding the core block, plus the captured
// result buffer with its byte read mux.
module crypt_byte_serdes
    import crypt_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr_en,
    input  logic [3:0]         i_wr_idx,
    input  logic [7:0]         i_wr_data,
    input  logic               i_cap_en,
    input  logic [BLOCK_W-1:0] i_cap_data,
    input  logic [3:0]         i_rd_idx,
    output logic [BLOCK_W-1:0] o_block,
    output logic [7:0]         o_rd_data
);

    logic [7:0] r_in_buf  [NBYTES];
    logic [7:0] r_out_buf [NBYTES];

    // Abort deliberately does not clear the block: it persists until the next job overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                r_in_buf[4'(i)] <= '0;
            end
        end else if (i_wr_en) begin
            r_in_buf[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                r_out_buf[4'(i)] <= '0;
            end
        end else if (i_cap_en) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                r_out_buf[4'(i)] <= i_cap_data[byte_lane(i) +: 8];
            end
        end
    end

    always_comb begin
        o_block = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            o_block[byte_lane(i) +: 8] = r_in_buf[4'(i)];
        end
    end

    assign o_rd_data = r_out_buf[i_rd_idx];

endmodule

// File: rtl/crypt_job_controller.sv
// One-job-at-a-time sequencer: command, byte-serial load, fixed-latency core
// run, byte-serial unload of the captured result.
module crypt_job_controller #(
    parameter int unsigned CORE_LAT = 12,
    parameter int unsigned NBYTES   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        abort,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_mode,
    input  logic [crypt_pkg::KEY_W-1:0] cmd_key,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_data,
    output logic                        out_last,
    output logic                        core_enable,
    output logic                        core_mode,
    output logic [crypt_pkg::KEY_W-1:0] core_key,
    output logic [crypt_pkg::BLOCK_W-1:0] core_block,
    input  logic [crypt_pkg::BLOCK_W-1:0] core_result,
    output logic                        busy
);

    import crypt_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);
    localparam logic [7:0] LAT_LAST = 8'(CORE_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_byte_idx;
    logic [7:0]        r_lat_cnt;
    logic              r_mode;
    logic [KEY_W-1:0]  r_key;

    logic w_cmd_hs;
    logic w_in_hs;
    logic w_out_hs;
    logic w_run_done;
    logic w_last_idx;

    assign w_last_idx = (r_byte_idx == LAST_IDX);

    // Abort outranks every handshake, so it gates them all here.
    assign w_cmd_hs   = (r_state == ST_IDLE)   && cmd_valid && !abort;
    assign w_in_hs    = (r_state == ST_LOAD)   && in_valid  && !abort;
    assign w_out_hs   = (r_state == ST_UNLOAD) && out_ready && !abort;
    assign w_run_done = (r_state == ST_RUN) && (r_lat_cnt == LAT_LAST) && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        core_enable = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_last_idx) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                core_enable = 1'b1;
                if (r_lat_cnt == LAT_LAST) begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = w_last_idx;
                if (out_ready && w_last_idx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_idx <= '0;
            r_lat_cnt  <= '0;
            r_mode     <= MODE_ENC;
            r_key      <= '0;
        end else if (abort) begin
            r_byte_idx <= '0;
            r_lat_cnt  <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_mode     <= cmd_mode;
                r_key      <= cmd_key;
                r_byte_idx <= '0;
            end
            if (w_in_hs) begin
                r_byte_idx <= r_byte_idx + 4'd1;
                if (w_last_idx) begin
                    r_lat_cnt <= '0;
                end
            end
            if (r_state == ST_RUN) begin
                r_lat_cnt <= r_lat_cnt + 8'd1;
                if (w_run_done) begin
                    r_byte_idx <= '0;
                end
            end
            if (w_out_hs) begin
                r_byte_idx <= r_byte_idx + 4'd1;
            end
        end
    end

    crypt_byte_serdes u_serdes (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_in_hs),
        .i_wr_idx   (r_byte_idx),
        .i_wr_data  (in_data),
        .i_cap_en   (w_run_done),
        .i_cap_data (core_result),
        .i_rd_idx   (r_byte_idx),
        .o_block    (core_block),
        .o_rd_data  (out_data)
    );

    assign core_mode = r_mode;
    assign core_key  = r_key;

endmodule
